// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-busy freeze
// and a saturating count of cycles in which the PC was held.
module hazard_ctrl_unit #(
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned X0_FILTER = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ID_EXmemRead,
    input  logic [REG_AW-1:0] ID_EXrd,
    input  logic [REG_AW-1:0] IF_IDrs1,
    input  logic [REG_AW-1:0] IF_IDrs2,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic              branch_taken,
    input  logic              mem_busy,
    input  logic              stat_clr,
    output logic              PCwrite,
    output logic              IF_IDwrite,
    output logic              ID_EXwrite,
    output logic              EX_MEMwrite,
    output logic              IF_IDflush,
    output logic              ID_EXflush,
    output logic              stall_active,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned REM_W = 4;
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] rem_nxt;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             x0_block;
    logic             lu_hit;

    // Load in EX writes a register the ID instruction actually reads.
    always_comb begin
        rs1_hit  = rs1_used && (ID_EXrd == IF_IDrs1);
        rs2_hit  = rs2_used && (ID_EXrd == IF_IDrs2);
        x0_block = (X0_FILTER != 0) && (ID_EXrd == '0);
        lu_hit   = ID_EXmemRead && (rs1_hit || rs2_hit) && !x0_block;
    end

    // Next-state and pipeline-control decode: reset > mem_busy > branch > load-use.
    always_comb begin
        state_nxt    = state;
        rem_nxt      = rem;
        PCwrite      = 1'b1;
        IF_IDwrite   = 1'b1;
        ID_EXwrite   = 1'b1;
        EX_MEMwrite  = 1'b1;
        IF_IDflush   = 1'b0;
        ID_EXflush   = 1'b0;
        stall_active = 1'b0;

        if (!reset) begin
            state_nxt  = RUN;
            rem_nxt    = '0;
            PCwrite    = 1'b0;
            IF_IDwrite = 1'b0;
            IF_IDflush = 1'b1;
            ID_EXflush = 1'b1;
        end else if (mem_busy) begin
            PCwrite      = 1'b0;
            IF_IDwrite   = 1'b0;
            ID_EXwrite   = 1'b0;
            EX_MEMwrite  = 1'b0;
            stall_active = (state == LU_STALL);
        end else if (branch_taken) begin
            // Squashing the ID instruction also cancels any pending stall.
            state_nxt    = RUN;
            rem_nxt      = '0;
            IF_IDflush   = 1'b1;
            ID_EXflush   = 1'b1;
            stall_active = (state == LU_STALL);
        end else if (state == LU_STALL) begin
            PCwrite      = 1'b0;
            IF_IDwrite   = 1'b0;
            ID_EXflush   = 1'b1;
            stall_active = 1'b1;
            rem_nxt      = rem - REM_W'(1);
            if (rem <= REM_W'(1)) begin
                state_nxt = RUN;
                rem_nxt   = '0;
            end
        end else if (lu_hit) begin
            PCwrite    = 1'b0;
            IF_IDwrite = 1'b0;
            ID_EXflush = 1'b1;
            if (LOAD_LAT > 1) begin
                state_nxt = LU_STALL;
                rem_nxt   = REM_INIT;
            end
        end
    end

    // State, remaining-stall counter and saturating statistics counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            rem       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            if (stat_clr) begin
                stall_cnt <= '0;
            end else if (!PCwrite && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
